// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               op encoding, FSM state encoding and the widened absolute
//               value helper.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // op encoding presented by EX (6 and 7 are no-ops)
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Widest supported operand; abs_ext works at this width plus one bit.
    localparam int MD_MAX_W = 64;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Absolute value of a sign-extended operand. The extra bit keeps the
    // magnitude of the most-negative value representable.
    function automatic logic [MD_MAX_W:0] abs_ext(input logic [MD_MAX_W:0] v);
        return v[MD_MAX_W] ? -v : v;
    endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_step.sv
`default_nettype none
// ============================================================================
// Module      : md_step
// Description : One radix-2 iteration of the multiply/divide datapath.
//               acc = {upper (WIDTH+1 bits), lower (WIDTH bits)}.
//               Multiply: upper += lower[0] ? opd : 0, then shift right 1.
//               Divide  : restoring step; shift {rem,quo} left 1, try rem-opd,
//                         keep the difference when it does not borrow.
// Ports       : is_div_i  - select divide step (1) or multiply step (0)
//               acc_i     - current accumulator pair
//               opd_i     - multiplicand / divisor magnitude
//               acc_o     - accumulator pair after one iteration
// Revision    : 1.0 - initial release
// ============================================================================
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH:0]     opd_i,
    output logic [2*WIDTH:0]   acc_o
);

    logic [WIDTH:0]   w_upper;
    logic [WIDTH-1:0] w_lower;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    assign w_upper = acc_i[2*WIDTH:WIDTH];
    assign w_lower = acc_i[WIDTH-1:0];

    // Partial product stays below 2^WIDTH, so the sum never overflows WIDTH+1.
    assign w_sum   = w_upper + (w_lower[0] ? opd_i : '0);

    // Remainder stays below the divisor, so dropping its top bit is lossless.
    assign w_shift = {w_upper[WIDTH-1:0], w_lower[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {1'b0, opd_i};

    always_comb begin
        acc_o = '0;
        if (is_div_i) begin
            if (!w_diff[WIDTH+1]) begin
                acc_o = {w_diff[WIDTH:0], w_lower[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {w_shift, w_lower[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {1'b0, w_sum, w_lower[WIDTH-1:1]};
        end
    end

endmodule : md_step
`default_nettype wire

// File: rtl/md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_iter_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//               Signed ops run on magnitudes and fix the sign in FIX.
//               Optional macro MDU_EARLY_OUT_EN enables early termination
//               (variable latency); undefined gives WIDTH+1 busy cycles.
// Ports       : CLK, PowerSwch (async active-low reset)
//               start/op/rs_val/rt_val - request from EX
//               abort                  - flush of the in-flight op
//               busy, done             - status to hazard logic / EX
//               hi_o, lo_o             - HI/LO registers
//               div_zero               - sticky divide-by-zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module md_iter_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             CLK,
    input  logic             PowerSwch,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(WIDTH);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH:0]     opd_q;
    logic               is_div_q, neg_res_q, neg_rem_q, dz_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   hi_d, lo_d;

    // ---------------------------------------------------------------- accept
    logic               w_signed;
    logic [MD_MAX_W:0]  w_rs_abs, w_rt_abs;
    logic [WIDTH:0]     w_rs_mag, w_rt_mag;

    assign w_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_rs_abs = abs_ext({{(MD_MAX_W+1-WIDTH){w_signed & rs_val[WIDTH-1]}}, rs_val});
    assign w_rt_abs = abs_ext({{(MD_MAX_W+1-WIDTH){w_signed & rt_val[WIDTH-1]}}, rt_val});
    assign w_rs_mag = w_rs_abs[WIDTH:0];
    assign w_rt_mag = w_rt_abs[WIDTH:0];

    // ------------------------------------------------------------- iteration
    logic [2*WIDTH:0]   w_step;
    logic [CNT_W-1:0]   w_cnt_dec;
    logic               w_calc_last;

    assign w_cnt_dec = cnt_q - c_cnt_one;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (w_step)
    );

    logic [2*WIDTH-1:0] w_prod_mag;

`ifdef MDU_EARLY_OUT_EN
    logic w_mul_rest_zero;
    logic w_div_early;

    // Multiplier bits not yet consumed sit in the low w_cnt_dec bits.
    always_comb begin
        w_mul_rest_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i < int'(w_cnt_dec)) && w_step[i]) begin
                w_mul_rest_zero = 1'b0;
            end
        end
    end

    assign w_div_early = is_div_q && (cnt_q == c_cnt_full) &&
                         ({1'b0, acc_q[WIDTH-1:0]} < opd_q);
    assign w_calc_last = (cnt_q == c_cnt_one) || (!is_div_q && w_mul_rest_zero);
    // Remaining shift-only iterations are applied in one barrel shift.
    assign w_prod_mag  = acc_q[2*WIDTH-1:0] >> cnt_q;
`else
    assign w_calc_last = (cnt_q == c_cnt_one);
    assign w_prod_mag  = acc_q[2*WIDTH-1:0];
`endif

    // ------------------------------------------------------------ sign fixup
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    always_comb begin
        w_prod = neg_res_q ? -w_prod_mag : w_prod_mag;
        w_quo  = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        w_rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            hi_d = w_rem;
            lo_d = w_quo;
        end else begin
            hi_d = w_prod[2*WIDTH-1:WIDTH];
            lo_d = w_prod[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge PowerSwch) begin
        if (!PowerSwch) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (start && !abort) begin
                        if (!op[2]) begin
                            is_div_q  <= op[1];
                            neg_res_q <= w_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            neg_rem_q <= w_signed & rs_val[WIDTH-1];
                            dz_q      <= op[1] & (rt_val == '0);
                            acc_q     <= {{(WIDTH+1){1'b0}},
                                          op[1] ? w_rs_mag[WIDTH-1:0] : w_rt_mag[WIDTH-1:0]};
                            opd_q     <= op[1] ? w_rt_mag : w_rs_mag;
                            cnt_q     <= c_cnt_full;
                            busy_q    <= 1'b1;
                            state_q   <= MD_CALC;
                        end else if (op == MD_MTHI) begin
                            hi_q <= rs_val;
                        end else if (op == MD_MTLO) begin
                            lo_q <= rs_val;
                        end
                    end
                end
                MD_CALC: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end
`ifdef MDU_EARLY_OUT_EN
                    else if (w_div_early) begin
                        // Dividend below divisor: quotient 0, remainder = dividend.
                        acc_q   <= {1'b0, acc_q[WIDTH-1:0], {WIDTH{1'b0}}};
                        state_q <= MD_FIX;
                    end
`endif
                    else begin
                        acc_q <= w_step;
                        cnt_q <= w_cnt_dec;
                        if (w_calc_last) begin
                            state_q <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= MD_IDLE;
                    if (!abort) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
    assign div_zero = dz_q;

endmodule : md_iter_unit
`default_nettype wire

// File: tb/tb_md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_iter_unit
// Description : Self-checking bench for md_iter_unit (WIDTH=32): directed
//               vector table, hand-written abort/reset sequences and random
//               operations checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_iter_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          PowerSwch = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  rs_val = '0;
    logic [W-1:0]  rt_val = '0;
    logic          abort = 1'b0;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi_o, lo_o;

    md_iter_unit #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .PowerSwch (PowerSwch),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .div_zero  (div_zero)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // reference architectural state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    task automatic ref_exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] v, u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin v = sa * sb; m_hi = v[63:32]; m_lo = v[31:0]; m_dz = 1'b0; end
            3'd1: begin v = {32'b0, a} * {32'b0, b}; m_hi = v[63:32]; m_lo = v[31:0]; m_dz = 1'b0; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1;
                end else begin
                    if (o == 3'd2) begin
                        sq = sa / sb; sr = sa % sb;
                        v = sq; u = sr;
                    end else begin
                        v = {32'b0, a} / {32'b0, b};
                        u = {32'b0, a} % {32'b0, b};
                    end
                    m_lo = v[31:0]; m_hi = u[31:0]; m_dz = 1'b0;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one request and check timing and results.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, output int cyc);
        int cycles;
        bit early_done;
        bit is_md;
        is_md = (o[2] == 1'b0);
        @(negedge CLK);
        chk({tag, "/done_low_before"}, {63'b0, done}, 64'd0);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge CLK);
        start = 1'b0;
        cycles = 0;
        early_done = 1'b0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            if (done !== 1'b0) early_done = 1'b1;
            @(negedge CLK);
        end
        if (cycles >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL %s/busy_timeout: busy still high after %0d cycles", tag, cycles);
        end
`ifdef MDU_EARLY_OUT_EN
        if (is_md)
            chk({tag, "/busy_cycles_in_range"}, {63'b0, (cycles >= 2 && cycles <= W+1)}, 64'd1);
        else
            chk({tag, "/busy_cycles"}, 64'(cycles), 64'd0);
`else
        chk({tag, "/busy_cycles"}, 64'(cycles), is_md ? 64'(W+1) : 64'd0);
`endif
        chk({tag, "/done_pulse"}, {63'b0, done}, {63'b0, is_md});
        chk({tag, "/done_while_busy"}, {63'b0, early_done}, 64'd0);
        chk({tag, "/hi"}, {32'b0, hi_o}, {32'b0, ehi});
        chk({tag, "/lo"}, {32'b0, lo_o}, {32'b0, elo});
        chk({tag, "/div_zero"}, {63'b0, div_zero}, {63'b0, edz});
        cyc = cycles;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        bit seen;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        //             op    rs            rt            HI            LO            dz
        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hCAFEF00D, 1'b1};
        vecs[7]  = '{3'd6, 32'h00000001, 32'h00000002, 32'h12345678, 32'hCAFEF00D, 1'b1};
        vecs[8]  = '{3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

        // ---- reset state
        #1 PowerSwch = 1'b0;
        #21;
        chk("reset/busy", {63'b0, busy}, 64'd0);
        chk("reset/done", {63'b0, done}, 64'd0);
        chk("reset/hi", {32'b0, hi_o}, 64'd0);
        chk("reset/lo", {32'b0, lo_o}, 64'd0);
        chk("reset/div_zero", {63'b0, div_zero}, 64'd0);
        @(negedge CLK);
        PowerSwch = 1'b1;

        // ---- directed vector table
        for (int i = 0; i < 11; i++) begin
            ref_exec(vecs[i].op, vecs[i].rs, vecs[i].rt);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz, cyc);
        end

        // ---- abort mid-CALC
        @(negedge CLK);
        start = 1'b1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        chk("abort/busy_before", {63'b0, busy}, 64'd1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort/busy_after", {63'b0, busy}, 64'd0);
        seen = done;
        repeat (3) begin @(negedge CLK); seen |= done; end
        chk("abort/no_done", {63'b0, seen}, 64'd0);
        chk("abort/hi", {32'b0, hi_o}, {32'b0, m_hi});
        chk("abort/lo", {32'b0, lo_o}, {32'b0, m_lo});

        // ---- abort and start together in IDLE
        start = 1'b1; abort = 1'b1; op = 3'd4; rs_val = 32'hDEADBEEF;
        @(negedge CLK);
        start = 1'b1; op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
        chk("abort_start/mthi_hi", {32'b0, hi_o}, {32'b0, m_hi});
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        chk("abort_start/mult_busy", {63'b0, busy}, 64'd0);
        repeat (2) @(negedge CLK);
        chk("abort_start/lo", {32'b0, lo_o}, {32'b0, m_lo});

        // ---- reset in the middle of CALC (after setting div_zero)
        ref_exec(3'd3, 32'd9, 32'd0);
        run_op("divu_zero", 3'd3, 32'd9, 32'd0, m_hi, m_lo, m_dz, cyc);
        @(negedge CLK);
        start = 1'b1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        #2 PowerSwch = 1'b0;
        #1;
        chk("midreset/busy", {63'b0, busy}, 64'd0);
        chk("midreset/hi", {32'b0, hi_o}, 64'd0);
        chk("midreset/lo", {32'b0, lo_o}, 64'd0);
        chk("midreset/div_zero", {63'b0, div_zero}, 64'd0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge CLK);
        PowerSwch = 1'b1;
        ref_exec(3'd1, 32'd9, 32'd3);
        run_op("multu_after_reset", 3'd1, 32'd9, 32'd3, 32'h0, 32'h1B, 1'b0, cyc);
`ifdef MDU_EARLY_OUT_EN
        chk("early_out/busy_le_3", {63'b0, (cyc <= 3)}, 64'd1);
`endif

        // ---- random operations against the reference model
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 5));
            ra = pick_val();
            rb = pick_val();
            ref_exec(ro, ra, rb);
            run_op($sformatf("rnd%0d_op%0d_%h_%h", k, ro, ra, rb), ro, ra, rb, m_hi, m_lo, m_dz, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_md_iter_unit
`default_nettype wire
